// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver slice.
// Holds the receiver state encoding, default frame/oversampling parameters,
// derived mid-bit constant, counter widths and the 3-input majority helper.
package uart_pkg;

  localparam int unsigned OVERSAMPLE_DEF = 5;
  localparam int unsigned DATA_BITS_DEF  = 8;
  localparam int unsigned MID            = OVERSAMPLE_DEF / 2;
  localparam int unsigned PHASE_W        = $clog2(OVERSAMPLE_DEF);
  localparam int unsigned BIT_W          = $clog2(DATA_BITS_DEF);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Input conditioning for the UART receiver.
// Ports:
//   clk, rst    - system clock, synchronous active-high reset
//   uart_clk_i  - 5x-baud square wave, synchronous to clk
//   rx_i        - asynchronous serial line (idle high)
//   rxs_o       - rx after a 2-flop synchroniser (resets to 1 = idle)
//   tick_o      - registered single-cycle pulse per uart_clk rising edge
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic uart_clk_i,
  input  logic rx_i,
  output logic rxs_o,
  output logic tick_o
);

  logic rx_meta_q, rx_meta_d;
  logic rxs_q, rxs_d;
  logic uclk_q, uclk_d;
  logic tick_q, tick_d;

  always_comb begin
    rx_meta_d = rx_i;
    rxs_d     = rx_meta_q;
    uclk_d    = uart_clk_i;
    tick_d    = uart_clk_i & ~uclk_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
      uclk_q    <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx_meta_d;
      rxs_q     <= rxs_d;
      uclk_q    <= uclk_d;
      tick_q    <= tick_d;
    end
  end

  assign rxs_o  = rxs_q;
  assign tick_o = tick_q;

endmodule

// File: rtl/uart_receiver.sv
// UART serial byte receiver (8N1 by default), oversampled by a uart_clk enable.
// Ports:
//   clk, rst   - system clock, synchronous active-high reset
//   uart_clk   - OVERSAMPLE x baud square wave; only its rising edges are used
//   rx         - asynchronous serial input, idle high
//   rx_data    - last good byte, held until the next good frame
//   rx_valid   - one-cycle pulse, rx_data is new
//   frame_err  - one-cycle pulse, stop bit was low and the byte was dropped
//   busy       - receiver is inside a frame
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = DATA_BITS_DEF,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 uart_clk,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned PhaseW = $clog2(OVERSAMPLE);
  localparam int unsigned BitW   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int unsigned Mid    = OVERSAMPLE / 2;

  localparam logic [PhaseW-1:0] PhFirst = PhaseW'(Mid - 1);
  localparam logic [PhaseW-1:0] PhMid   = PhaseW'(Mid);
  localparam logic [PhaseW-1:0] PhDec   = PhaseW'(Mid + 1);
  localparam logic [PhaseW-1:0] PhLast  = PhaseW'(OVERSAMPLE - 1);
  localparam logic [PhaseW-1:0] PhOne   = PhaseW'(1);
  localparam logic [BitW-1:0]   BitLast = BitW'(DATA_BITS - 1);

  logic rxs, tick;

  uart_rx_sync u_sync (
    .clk        (clk),
    .rst        (rst),
    .uart_clk_i (uart_clk),
    .rx_i       (rx),
    .rxs_o      (rxs),
    .tick_o     (tick)
  );

  rx_state_e            state_q, state_d;
  logic [PhaseW-1:0]    phase_q, phase_d;
  logic [BitW-1:0]      bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [1:0]           samp_q, samp_d;
  logic                 armed_q, armed_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;

  logic maj;
  logic last_phase;
  logic decide;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    samp_d      = samp_q;
    armed_d     = armed_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;

    // Third sample is the live rxs on the decision tick.
    maj        = maj3(samp_q[0], samp_q[1], rxs);
    last_phase = (phase_q == PhLast);
    decide     = (phase_q == PhDec);

    if (tick) begin
      // IDLE holds phase 0, so with OVERSAMPLE=3 the start-detect tick is sample 0.
      if (phase_q == PhFirst) samp_d[0] = rxs;
      if (phase_q == PhMid)   samp_d[1] = rxs;
      phase_d = last_phase ? '0 : phase_q + 1'b1;

      unique case (state_q)
        StIdle: begin
          phase_d = '0;
          if (rxs) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            state_d = StStart;
            phase_d = PhOne;
          end
        end
        StStart: begin
          if (decide && maj) begin
            state_d = StIdle;
            phase_d = '0;
          end else if (last_phase) begin
            state_d   = StData;
            bit_idx_d = '0;
          end
        end
        StData: begin
          if (decide) shift_d = {maj, shift_q[DATA_BITS-1:1]};
          if (last_phase) begin
            if (bit_idx_q == BitLast) state_d = StStop;
            else                      bit_idx_d = bit_idx_q + 1'b1;
          end
        end
        StStop: begin
          // Leave at the decision point so the next start edge is caught early.
          if (decide) begin
            state_d = StIdle;
            phase_d = '0;
            if (maj) begin
              rx_valid_d = 1'b1;
              rx_data_d  = shift_q;
            end else begin
              frame_err_d = 1'b1;
              // A held-low line must go high before another start is accepted.
              armed_d     = 1'b0;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      phase_q     <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      samp_q      <= '0;
      armed_q     <= 1'b1;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      samp_q      <= samp_d;
      armed_q     <= armed_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != StIdle);

endmodule
